encoder4to2_stream: RTL and testbench
=====================================

Name: encoder4to2_stream

Overview:
- Sequential counterpart of the team's 2-to-4 decoder: converts event pulses on N one-hot-style request lines into a stream of binary indices.
- Events are captured into a pending register and emitted one at a time through a valid/ready output port, highest index first.
- Sits at the upstream end of the decoder path, so that decoder(A) reproduces each event line.

Parameters:
- N, 4, number of input event lines (power of two, >= 2)
- AW, $clog2(N) = 2, output index width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- E  input  1  input enable; when 0, D is ignored
- D  input  N  event pulses; bit i high in a cycle = one event on line i
- A  output  AW  encoded index of the event being offered
- out_valid  output  1  A holds a valid index
- out_ready  input  1  consumer accepts A when out_valid && out_ready at an edge
- pending  output  N  events captured but not yet loaded into A
- ovf  output  1  one-cycle pulse: a new event merged into an already-pending bit

Behaviour:
- Reset: all sequential state changes only at a rising clk edge.
  - On an edge with rst=1: pending=0, A=0, out_valid=0, ovf=0 and state=IDLE. D and out_ready are ignored on that edge.
  - Reset mid-operation discards every pending and offered event.
- Input capture:
  - in_vec = E ? D : 0.
  - cand = pending | in_vec.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- IDLE, cand != 0:
  - A <= the selected index of cand; default selection is the highest set bit.
  - pending <= cand with the selected bit cleared.
  - Go to HOLD.
  - Latency: a pulse sampled at edge k gives out_valid=1 after edge k, with no other traffic.
- IDLE, cand == 0: stay in IDLE.
- HOLD, not accepted (out_ready=0): A and out_valid hold stable; pending <= cand.
- HOLD, accepted:
  - If cand != 0: load the next index from cand the same way as from IDLE; stay in HOLD. Back-to-back issue, one index per cycle.
  - Else: go to IDLE, out_valid <= 0.
- Same-bit events:
  - An event on the bit currently held in A is a new event and enters pending.
  - An event on a bit already set in pending merges into it: the count is lost, and ovf=1 for the next cycle only.
  - Simultaneous events on several lines are all captured in the same edge.
- E=0: new events are ignored; pending events keep draining normally.
- A changes only on a load; its value is don't-care for the consumer while out_valid=0 but stays at its last value.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined:
  - The module keeps a register last_grant, reset to 0.
  - The search order starts at (last_grant-1) mod N and descends, wrapping from 0 to N-1.
  - last_grant updates on every load.
  - After reset, the first search starts at N-1, identical to fixed priority.
- Undefined: fixed highest-index-first priority; no last_grant register.

Decomposition:
- Package enc_pkg holds:
  - constants N_DEF=4 and AW_DEF=2
  - typedef enum state_t {IDLE, HOLD}
- Sub-module prio_sel_n: combinational; inputs vec[N-1:0] and start[AW-1:0]; outputs idx[AW-1:0] and any.
  - Fixed mode ties start to N-1.

Test Plan:
- Reset, E=1, D=0001 for 1 cycle, out_ready=1 -> after the next edge out_valid=1, A=00; one edge later out_valid=0, pending=0000.
- D=1111 for 1 cycle, out_ready=1 -> A=11,10,01,00 on 4 consecutive cycles; then out_valid=0, ovf never asserted.
- E=0, D=1111 for 3 cycles -> out_valid stays 0, pending=0000.
- D=0110, out_ready=0 for 5 cycles -> A=10 held stable with out_valid=1, pending=0010; raise out_ready -> next cycle A=01, then idle.
- D=1100, out_ready=0 -> A=11, pending=0100; D=0100 again -> ovf=1 for exactly one cycle, pending unchanged; assert rst with pending nonzero -> next edge out_valid=0, pending=0000, A=00.
- With ENC_ROUND_ROBIN_EN: D=1010 pulses every cycle, out_ready=1 -> grants alternate 11,01,11,01; without the macro, 11 every cycle.

Source files
------------

// File: rtl/encoder4to2_stream_pkg.sv
// Shared constants and FSM state type for the event-to-index stream encoder.
package enc_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/encoder4to2_stream_prio_sel.sv
// Combinational priority selector: finds the first set bit of vec searching
// downward from index start, wrapping from 0 back to N-1.
module prio_sel_n
    import enc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [N-1:0]  vec,
    input  logic [AW-1:0] start,
    output logic [AW-1:0] idx,
    output logic          any
);

    logic [AW-1:0] w_pos;
    logic          w_found;

    // N is a power of two, so the AW-bit subtraction wraps the search naturally
    always_comb begin
        idx     = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = start - AW'(k);
            if (!w_found && vec[w_pos]) begin
                idx     = w_pos;
                w_found = 1'b1;
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/encoder4to2_stream.sv
// Captures event pulses into a pending set and streams their indices out over valid/ready.
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is fixed highest-index-first.
module encoder4to2_stream
    import enc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          E,
    input  logic [N-1:0]  D,
    output logic [AW-1:0] A,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  pending,
    output logic          ovf
);

    state_t        r_state;
    logic [N-1:0]  r_pending;
    logic [AW-1:0] r_a;
    logic          r_ovf;

    logic [N-1:0]  w_inVec;
    logic [N-1:0]  w_cand;
    logic [N-1:0]  w_selMask;
    logic [AW-1:0] w_selIdx;
    logic [AW-1:0] w_start;
    logic          w_candAny;
    logic          w_accept;
    logic          w_load;

    always_comb begin
        w_inVec = E ? D : '0;
        w_cand  = r_pending | w_inVec;
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [AW-1:0] r_lastGrant;

    // Reset value 0 makes the first search start at N-1, same as fixed priority
    assign w_start = r_lastGrant - AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= '0;
        end else if (w_load) begin
            r_lastGrant <= w_selIdx;
        end
    end
`else
    assign w_start = AW'(N - 1);
`endif

    prio_sel_n #(
        .N  (N),
        .AW (AW)
    ) u_prioSel (
        .vec   (w_cand),
        .start (w_start),
        .idx   (w_selIdx),
        .any   (w_candAny)
    );

    assign w_selMask = {{(N-1){1'b0}}, 1'b1} << w_selIdx;
    assign w_accept  = (r_state == HOLD) && out_ready;
    assign w_load    = w_candAny && ((r_state == IDLE) || w_accept);

    // An event on the index currently in A is not in pending, so it counts as new
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_a       <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= |(w_inVec & r_pending);
            if (w_load) begin
                r_a       <= w_selIdx;
                r_pending <= w_cand & ~w_selMask;
                r_state   <= HOLD;
            end else begin
                r_pending <= w_cand;
                if (w_accept) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign A         = r_a;
    assign out_valid = (r_state == HOLD);
    assign pending   = r_pending;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_encoder4to2_stream.sv
// Directed self-checking bench for encoder4to2_stream (N=4), expectations hand-computed.
module tb_encoder4to2_stream;

    logic       clk;
    logic       rst;
    logic       E;
    logic [3:0] D;
    logic [1:0] A;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic       ovf;

    int compareCount  = 0;
    int mismatchCount = 0;

    encoder4to2_stream #(.N(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .E         (E),
        .D         (D),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then advance one edge and settle past it before sampling
    task automatic applyStimulus(input logic e, input logic [3:0] d, input logic rdy);
        E         = e;
        D         = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic v, input logic [1:0] a,
                              input logic [3:0] p, input logic o);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, ".A"},     32'(A),         32'(a));
        checkOutput({tag, ".pend"},  32'(pending),   32'(p));
        checkOutput({tag, ".ovf"},   32'(ovf),       32'(o));
    endtask

    logic [1:0] rrExp [4];

    initial begin
        rst = 1'b1; E = 1'b0; D = 4'b0000; out_ready = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
        checkState("reset", 1'b0, 2'd0, 4'b0000, 1'b0);

        // single pulse on line 0
        applyStimulus(1'b1, 4'b0001, 1'b1);
        checkState("single.load", 1'b1, 2'd0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("single.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // all four lines at once drain highest first
        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkState("all.3", 1'b1, 2'd3, 4'b0111, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("all.2", 1'b1, 2'd2, 4'b0011, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("all.1", 1'b1, 2'd1, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("all.0", 1'b1, 2'd0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("all.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // disabled input ignores events
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            checkState("disabled", 1'b0, 2'd0, 4'b0000, 1'b0);
        end

        // backpressure holds A stable
        applyStimulus(1'b1, 4'b0110, 1'b0);
        checkState("bp.load", 1'b1, 2'd2, 4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0);
            checkState("bp.hold", 1'b1, 2'd2, 4'b0010, 1'b0);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("bp.next", 1'b1, 2'd1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkState("bp.idle", 1'b0, 2'd1, 4'b0000, 1'b0);

        // held-bit event is new, pending-bit event overflows, then reset clears it
        applyStimulus(1'b1, 4'b1100, 1'b0);
        checkState("ovf.load", 1'b1, 2'd3, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b0);
        checkState("ovf.heldbit", 1'b1, 2'd3, 4'b1100, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkState("ovf.merge", 1'b1, 2'd3, 4'b1100, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkState("ovf.clear", 1'b1, 2'd3, 4'b1100, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b1111, 1'b1);
        rst = 1'b0;
        checkState("midreset", 1'b0, 2'd0, 4'b0000, 1'b0);

        // repeated 1010 pulses: rotation only with round-robin enabled
`ifdef ENC_ROUND_ROBIN_EN
        rrExp[0] = 2'd3; rrExp[1] = 2'd1; rrExp[2] = 2'd3; rrExp[3] = 2'd1;
`else
        rrExp[0] = 2'd3; rrExp[1] = 2'd3; rrExp[2] = 2'd3; rrExp[3] = 2'd3;
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b1010, 1'b1);
            checkOutput("rr.valid", 32'(out_valid), 32'd1);
            checkOutput("rr.A", 32'(A), 32'(rrExp[i]));
        end

        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("rr.drain", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
